alu_seq: RTL and testbench

- Parametrised, registered successor to the 8-bit combinational ALU.
- Operand width is generic. Opcode space grows to 16 operations: adds XOR, shifts, carry-chained add/subtract and a multi-cycle shift-add multiply.
- Status flags (Z, N, C, V) are registered.
- A start/busy/done handshake lets the multi-cycle controller in the datapath sequence operations.

---
 rtl/alu_seq.sv | 270 +++++++++++++++++++++++++++
 tb/tb_alu_seq.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: registered, parametrised ALU with a multi-cycle shift-add multiplier.
//
// Ports:
//   clk     in   rising-edge system clock
//   rst     in   asynchronous active-high reset
//   start   in   request; accepted on a clock edge when start=1 and busy=0
//   a, b    in   WIDTH-bit operands, sampled at acceptance
//   sel     in   4-bit opcode, sampled at acceptance (14 = multi-cycle MUL)
//   out     out  WIDTH-bit result (low half of the product for MUL)
//   out_hi  out  high half of the product for MUL, 0 after any other op
//   flag_z  out  out == 0
//   flag_n  out  out msb
//   flag_c  out  carry / borrow / shifted-out bit (product high half != 0 for MUL)
//   flag_v  out  signed overflow
//   busy    out  multiply in progress; start is ignored while high
//   done    out  high for the cycle after results were updated
module alu_seq #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       sel,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_hi,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             flag_v,
    output logic             busy,
    output logic             done
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

    localparam logic [3:0]       OP_MUL = 4'd14;
    localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [CNT_W-1:0]       cnt_r;
    logic [WIDTH-1:0]       mcand_r;
    // Upper half accumulates partial products, lower half holds the
    // not-yet-consumed multiplier bits; both shift right once per iteration.
    logic [2*WIDTH-1:0]     acc_r;
    logic [2*WIDTH-1:0]     acc_nxt_s;
    logic [WIDTH:0]         step_sum_s;

    logic                   accept_s;
    logic                   op_load_s;
    logic                   mul_load_s;
    logic                   mul_step_s;
    logic                   mul_last_s;

    logic [WIDTH-1:0]       res_s;
    logic [WIDTH:0]         sum_s;
    logic                   c_s;
    logic                   v_s;

    // Signed overflow of x + y (+carry): same-sign operands, result sign differs.
    function automatic logic add_ovf(input logic [WIDTH-1:0] x,
                                     input logic [WIDTH-1:0] y,
                                     input logic [WIDTH-1:0] r);
        return (x[WIDTH-1] == y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
    endfunction

    // Signed overflow of x - y (-borrow): opposite-sign operands, result sign differs from x.
    function automatic logic sub_ovf(input logic [WIDTH-1:0] x,
                                     input logic [WIDTH-1:0] y,
                                     input logic [WIDTH-1:0] r);
        return (x[WIDTH-1] != y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
    endfunction

    assign accept_s = start && !busy;

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic; the last iteration is the one that takes the counter to 0.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s && (sel == OP_MUL)) begin
                    state_nxt_s = MUL;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            MUL: begin
                if (cnt_r == CNT_W'(1)) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = MUL;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM output decode: datapath load/step strobes.
    always_comb begin
        op_load_s  = 1'b0;
        mul_load_s = 1'b0;
        mul_step_s = 1'b0;
        mul_last_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    mul_load_s = (sel == OP_MUL);
                    op_load_s  = (sel != OP_MUL);
                end else begin
                    mul_load_s = 1'b0;
                    op_load_s  = 1'b0;
                end
            end
            MUL: begin
                mul_step_s = 1'b1;
                mul_last_s = (cnt_r == CNT_W'(1));
            end
            default: begin
                mul_step_s = 1'b0;
            end
        endcase
    end

    // One shift-add iteration: conditionally add the multiplicand, then shift right.
    always_comb begin
        if (acc_r[0]) begin
            step_sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, mcand_r};
        end else begin
            step_sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]};
        end
        acc_nxt_s = {step_sum_s, acc_r[WIDTH-1:1]};
    end

    // Multiplier registers: operand latch, accumulator and iteration counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand_r <= {WIDTH{1'b0}};
            acc_r   <= {(2*WIDTH){1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
        end else if (mul_load_s) begin
            mcand_r <= a;
            acc_r   <= {{WIDTH{1'b0}}, b};
            cnt_r   <= CNT_W'(WIDTH);
        end else if (mul_step_s) begin
            acc_r   <= acc_nxt_s;
            cnt_r   <= cnt_r - CNT_W'(1);
        end else begin
            acc_r   <= acc_r;
            cnt_r   <= cnt_r;
        end
    end

    // Single-cycle result and carry/overflow; flag_c is the chained carry-in for ADC/SBC.
    always_comb begin
        res_s = {WIDTH{1'b0}};
        sum_s = {(WIDTH+1){1'b0}};
        c_s   = 1'b0;
        v_s   = 1'b0;
        case (sel)
            4'd0:  res_s = a;
            4'd1:  res_s = a & b;
            4'd2:  res_s = a | b;
            4'd3:  res_s = ~a;
            4'd4: begin
                sum_s = {1'b0, a} + {1'b0, b};
                res_s = sum_s[WIDTH-1:0];
                c_s   = sum_s[WIDTH];
                v_s   = add_ovf(a, b, res_s);
            end
            4'd5: begin
                sum_s = {1'b0, a} - {1'b0, b};
                res_s = sum_s[WIDTH-1:0];
                c_s   = sum_s[WIDTH];
                v_s   = sub_ovf(a, b, res_s);
            end
            4'd6: begin
                sum_s = {1'b0, a} + {1'b0, ONE};
                res_s = sum_s[WIDTH-1:0];
                c_s   = sum_s[WIDTH];
                v_s   = add_ovf(a, ONE, res_s);
            end
            4'd7: begin
                sum_s = {1'b0, a} - {1'b0, ONE};
                res_s = sum_s[WIDTH-1:0];
                c_s   = sum_s[WIDTH];
                v_s   = sub_ovf(a, ONE, res_s);
            end
            4'd8:  res_s = a ^ b;
            4'd9: begin
                res_s = {a[WIDTH-2:0], 1'b0};
                c_s   = a[WIDTH-1];
            end
            4'd10: begin
                res_s = {1'b0, a[WIDTH-1:1]};
                c_s   = a[0];
            end
            4'd11: begin
                res_s = {a[WIDTH-1], a[WIDTH-1:1]};
                c_s   = a[0];
            end
            4'd12: begin
                sum_s = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, flag_c};
                res_s = sum_s[WIDTH-1:0];
                c_s   = sum_s[WIDTH];
                v_s   = add_ovf(a, b, res_s);
            end
            4'd13: begin
                sum_s = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, flag_c};
                res_s = sum_s[WIDTH-1:0];
                c_s   = sum_s[WIDTH];
                v_s   = sub_ovf(a, b, res_s);
            end
            4'd15: res_s = b;
            default: res_s = {WIDTH{1'b0}};
        endcase
    end

    // Result, flag and handshake registers; results hold between completions.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out    <= {WIDTH{1'b0}};
            out_hi <= {WIDTH{1'b0}};
            flag_z <= 1'b0;
            flag_n <= 1'b0;
            flag_c <= 1'b0;
            flag_v <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else if (op_load_s) begin
            out    <= res_s;
            out_hi <= {WIDTH{1'b0}};
            flag_z <= (res_s == {WIDTH{1'b0}});
            flag_n <= res_s[WIDTH-1];
            flag_c <= c_s;
            flag_v <= v_s;
            busy   <= 1'b0;
            done   <= 1'b1;
        end else if (mul_load_s) begin
            busy   <= 1'b1;
            done   <= 1'b0;
        end else if (mul_last_s) begin
            out    <= acc_nxt_s[WIDTH-1:0];
            out_hi <= acc_nxt_s[2*WIDTH-1:WIDTH];
            flag_z <= (acc_nxt_s[WIDTH-1:0] == {WIDTH{1'b0}});
            flag_n <= acc_nxt_s[WIDTH-1];
            flag_c <= (acc_nxt_s[2*WIDTH-1:WIDTH] != {WIDTH{1'b0}});
            flag_v <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b1;
        end else begin
            done   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=8): directed plan scenarios plus
// randomized single-cycle and multiply traffic against an integer-arithmetic model.
module tb_alu_seq;

    localparam int W = 8;
    localparam int M = 1 << W;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   sel;
    logic [W-1:0] out;
    logic [W-1:0] out_hi;
    logic         flag_z;
    logic         flag_n;
    logic         flag_c;
    logic         flag_v;
    logic         busy;
    logic         done;

    int checks = 0;
    int errors = 0;

    // Model state: expected architectural results.
    int   e_out = 0;
    int   e_hi  = 0;
    logic e_z   = 1'b0;
    logic e_n   = 1'b0;
    logic e_c   = 1'b0;
    logic e_v   = 1'b0;

    logic [2*W+5:0] obs;
    assign obs = {out, out_hi, flag_z, flag_n, flag_c, flag_v, busy, done};

    alu_seq #(.WIDTH(W), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .sel(sel),
        .out(out), .out_hi(out_hi), .flag_z(flag_z), .flag_n(flag_n),
        .flag_c(flag_c), .flag_v(flag_v), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [2*W+5:0] expv(input logic eb, input logic ed);
        return {W'(e_out), W'(e_hi), e_z, e_n, e_c, e_v, eb, ed};
    endfunction

    task automatic model_reset();
        e_out = 0; e_hi = 0; e_z = 1'b0; e_n = 1'b0; e_c = 1'b0; e_v = 1'b0;
    endtask

    // Reference behaviour from plain integer arithmetic.
    task automatic model_apply(input int s, input int x, input int y);
        int full, sres, sa, sb, ci, r;
        ci = e_c ? 1 : 0;
        sa = (x >= M/2) ? x - M : x;
        sb = (y >= M/2) ? y - M : y;
        r = 0; e_hi = 0; e_c = 1'b0; e_v = 1'b0; sres = 0;
        case (s)
            0:  r = x;
            1:  r = x & y;
            2:  r = x | y;
            3:  r = (M - 1) - x;
            4:  begin full = x + y;      r = full % M; e_c = (full >= M); sres = sa + sb; end
            5:  begin full = x - y;      r = (full + M) % M; e_c = (full < 0); sres = sa - sb; end
            6:  begin full = x + 1;      r = full % M; e_c = (full >= M); sres = sa + 1; end
            7:  begin full = x - 1;      r = (full + M) % M; e_c = (full < 0); sres = sa - 1; end
            8:  r = x ^ y;
            9:  begin r = (2 * x) % M; e_c = (x >= M/2); end
            10: begin r = x / 2; e_c = (x % 2 == 1); end
            11: begin r = x / 2 + ((x >= M/2) ? M/2 : 0); e_c = (x % 2 == 1); end
            12: begin full = x + y + ci; r = full % M; e_c = (full >= M); sres = sa + sb + ci; end
            13: begin full = x - y - ci; r = (full + 2*M) % M; e_c = (full < 0); sres = sa - sb - ci; end
            14: begin full = x * y; r = full % M; e_hi = full / M; e_c = (e_hi != 0); end
            default: r = y;
        endcase
        if (s == 4 || s == 5 || s == 6 || s == 7 || s == 12 || s == 13)
            e_v = (sres > M/2 - 1) || (sres < -(M/2));
        e_out = r;
        e_z = (r == 0);
        e_n = (r >= M/2);
    endtask

    // Present one request so it is sampled at the next rising edge; returns #1 after it.
    task automatic drive(input int s, input int x, input int y);
        @(negedge clk);
        start = 1'b1; sel = 4'(s); a = W'(x); b = W'(y);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic idle();
        @(negedge clk);
        start = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; a = '0; b = '0; sel = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (obs !== '0) begin errors++; $display("FAIL reset_init got %h exp 0", obs); end
        @(negedge clk); rst = 1'b0;
        drive(3, 0, 0); model_apply(3, 0, 0);
        checks++;
        if (obs !== expv(1'b0, 1'b1)) begin errors++; $display("FAIL pre_reset_op got %h exp %h", obs, expv(1'b0, 1'b1)); end
        #2 rst = 1'b1;
        #1;
        model_reset();
        checks++;
        if (obs !== '0) begin errors++; $display("FAIL async_reset got %h exp 0", obs); end
        @(negedge clk); rst = 1'b0;
        drive(4, 'h7F, 'h01); model_apply(4, 'h7F, 'h01);
        checks++;
        if (obs !== expv(1'b0, 1'b1) || out !== 8'h80 || {flag_z, flag_n, flag_c, flag_v} !== 4'b0101) begin
            errors++; $display("FAIL add_7f_01 got %h exp %h", obs, expv(1'b0, 1'b1));
        end
        idle();
        checks++;
        if (obs !== expv(1'b0, 1'b0)) begin errors++; $display("FAIL done_one_cycle got %h exp %h", obs, expv(1'b0, 1'b0)); end
    endtask

    // Carry chain, borrow chain and shifts, back-to-back with fixed expectations.
    task automatic test_chain_shift();
        int ts[7] = '{4, 12, 5, 13, 11, 10, 9};
        int ta[7] = '{'hFF, 'h00, 'h00, 'h05, 'h81, 'h81, 'h81};
        int tb[7] = '{'h01, 'h00, 'h01, 'h02, 'h00, 'h00, 'h00};
        int to[7] = '{'h00, 'h01, 'hFF, 'h02, 'hC0, 'h40, 'h02};
        int tc[7] = '{1, 0, 1, 0, 1, 1, 1};
        for (int i = 0; i < 7; i++) begin
            drive(ts[i], ta[i], tb[i]); model_apply(ts[i], ta[i], tb[i]);
            checks++;
            if (obs !== expv(1'b0, 1'b1) || out !== W'(to[i]) || flag_c !== tc[i][0]) begin
                errors++; $display("FAIL chain_shift[%0d] got %h exp %h (out %h c %0d)", i, obs, expv(1'b0, 1'b1), to[i], tc[i]);
            end
        end
        idle();
    endtask

    task automatic test_mul(input int x, input int y, input bit use_const, input int clo, input int chi);
        int n = 0;
        drive(14, x, y);
        checks++;
        if (obs !== expv(1'b1, 1'b0)) begin errors++; $display("FAIL mul_start got %h exp %h", obs, expv(1'b1, 1'b0)); end
        while (busy === 1'b1 && n < 4 * W) begin
            @(negedge clk);
            if (n == 2) begin start = 1'b1; sel = 4'd0; a = 8'h5A; b = 8'hA5; end
            @(posedge clk); #1;
            start = 1'b0;
            n++;
            if (busy === 1'b1) begin
                checks++;
                if (obs !== expv(1'b1, 1'b0)) begin errors++; $display("FAIL mul_hold got %h exp %h", obs, expv(1'b1, 1'b0)); end
            end
        end
        checks++;
        if (n != W) begin errors++; $display("FAIL mul_busy_len got %0d exp %0d", n, W); end
        model_apply(14, x, y);
        checks++;
        if (obs !== expv(1'b0, 1'b1)) begin errors++; $display("FAIL mul_result got %h exp %h", obs, expv(1'b0, 1'b1)); end
        if (use_const) begin
            checks++;
            if (out !== W'(clo) || out_hi !== W'(chi)) begin
                errors++; $display("FAIL mul_const got %h/%h exp %h/%h", out_hi, out, chi, clo);
            end
        end
        idle();
        checks++;
        if (obs !== expv(1'b0, 1'b0)) begin errors++; $display("FAIL mul_done_pulse got %h exp %h", obs, expv(1'b0, 1'b0)); end
    endtask

    task automatic test_abort();
        int seen = 0;
        drive(14, 'h10, 'h10);
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        model_reset();
        checks++;
        if (obs !== '0) begin errors++; $display("FAIL abort_reset got %h exp 0", obs); end
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            idle();
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL abort_no_done got %0d exp 0", seen); end
        drive(15, 0, 'hAA); model_apply(15, 0, 'hAA);
        checks++;
        if (obs !== expv(1'b0, 1'b1) || out !== 8'hAA) begin errors++; $display("FAIL abort_recover got %h exp %h", obs, expv(1'b0, 1'b1)); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 24; i++) begin
            int s = $urandom_range(0, 14);
            int x = $urandom_range(0, M - 1);
            int y = $urandom_range(0, M - 1);
            if (s == 14) s = 15;
            drive(s, x, y); model_apply(s, x, y);
            checks++;
            if (obs !== expv(1'b0, 1'b1)) begin errors++; $display("FAIL b2b sel %0d a %h b %h got %h exp %h", s, x, y, obs, expv(1'b0, 1'b1)); end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 150; i++) begin
            int r = $urandom_range(0, 9);
            int s = $urandom_range(0, 15);
            int x = $urandom_range(0, M - 1);
            int y = $urandom_range(0, M - 1);
            if (r < 2) begin
                idle();
                checks++;
                if (obs !== expv(1'b0, 1'b0)) begin errors++; $display("FAIL rnd_idle got %h exp %h", obs, expv(1'b0, 1'b0)); end
            end else if (r == 2 || s == 14) begin
                test_mul(x, y, 1'b0, 0, 0);
            end else begin
                drive(s, x, y); model_apply(s, x, y);
                checks++;
                if (obs !== expv(1'b0, 1'b1)) begin errors++; $display("FAIL rnd_op sel %0d a %h b %h got %h exp %h", s, x, y, obs, expv(1'b0, 1'b1)); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_chain_shift();
        test_mul('hFF, 'hFF, 1'b1, 'h01, 'hFE);
        test_mul(3, 5, 1'b1, 15, 0);
        test_abort();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
